i2c_interconnect_arb: RTL

I2C_INTERCONNECT_ARB -- requirements
Module: i2c_interconnect_arb

---
 rtl/i2c_interconnect_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_interconnect_arb.sv
// Wired-AND I2C interconnect between internal controllers and open-drain pads,
// with a filtered bus monitor that tracks START/STOP, ownership and stuck-SCL.
module i2c_interconnect_arb #(
  parameter int N_CTRL        = 4,
  parameter int N_DEV         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILT_LEN      = 3,
  parameter int STUCK_TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CTRL-1:0]           ctrl_en,
  input  logic                        excl_en,
  input  logic [N_CTRL-1:0]           ctrl_scl_o,
  input  logic [N_CTRL-1:0]           ctrl_sda_o,
  input  logic [N_CTRL-1:0]           ctrl_scl_t,
  input  logic [N_CTRL-1:0]           ctrl_sda_t,
  output logic [N_CTRL-1:0]           ctrl_scl_i,
  output logic [N_CTRL-1:0]           ctrl_sda_i,
  input  logic [N_DEV-1:0]            dev_scl_i,
  input  logic [N_DEV-1:0]            dev_sda_i,
  output logic [N_DEV-1:0]            dev_scl_o,
  output logic [N_DEV-1:0]            dev_sda_o,
  output logic [N_DEV-1:0]            dev_scl_t,
  output logic [N_DEV-1:0]            dev_sda_t,
  output logic                        bus_busy,
  output logic [$clog2(N_CTRL+1)-1:0] bus_owner,
  output logic                        bus_stuck,
  output logic [15:0]                 start_cnt
);

  localparam int OW = $clog2(N_CTRL + 1);
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int CW = $clog2(STUCK_TIMEOUT + 1);
  localparam logic [OW-1:0] OWNER_NONE = OW'(N_CTRL);
  localparam logic [CW-1:0] STUCK_MAX  = CW'(STUCK_TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_STUCK = 2'd2;

  logic [1:0]             state_reg, state_next;
  logic [OW-1:0]          owner_reg, owner_next;
  logic [15:0]            start_cnt_reg, start_cnt_next;
  logic [CW-1:0]          stuck_cnt_reg, stuck_cnt_next;
  logic [SYNC_STAGES-1:0] scl_sync_reg, sda_sync_reg;
  logic [1:0]             filt_reg, filt_next;
  logic [FW-1:0]          filt_cnt_reg  [2];
  logic [FW-1:0]          filt_cnt_next [2];

  logic [N_CTRL-1:0] masked, scl_pull, sda_pull;
  logic              scl_low, sda_low, scl_res, sda_res;
  logic [1:0]        sync_out;
  logic              scl_prev, scl_cur, sda_prev, sda_cur;
  logic              start_det, stop_det;
  logic [OW-1:0]     owner_cand;

  // Non-owners are gated off only while a real controller holds the bus exclusively.
  for (genvar gi = 0; gi < N_CTRL; gi++) begin : g_ctrl
    assign masked[gi]   = excl_en & bus_busy & (owner_reg != OWNER_NONE) & (owner_reg != OW'(gi));
    assign scl_pull[gi] = ctrl_en[gi] & ~ctrl_scl_t[gi] & ~ctrl_scl_o[gi] & ~masked[gi];
    assign sda_pull[gi] = ctrl_en[gi] & ~ctrl_sda_t[gi] & ~ctrl_sda_o[gi] & ~masked[gi];
    assign ctrl_scl_i[gi] = scl_res;
    assign ctrl_sda_i[gi] = sda_res;
  end

  assign scl_low = |scl_pull;
  assign sda_low = |sda_pull;
  assign scl_res = ~scl_low & (&dev_scl_i);
  assign sda_res = ~sda_low & (&dev_sda_i);

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
    assign dev_scl_o[gi] = 1'b0;
    assign dev_sda_o[gi] = 1'b0;
    assign dev_scl_t[gi] = ~scl_low;
    assign dev_sda_t[gi] = ~sda_low;
  end

  // Synchronizers shift in at bit 0 and present the settled value at the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_res};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_res};
    end
  end

  assign sync_out = {sda_sync_reg[SYNC_STAGES-1], scl_sync_reg[SYNC_STAGES-1]};

  // Counter tracks consecutive samples disagreeing with the filtered level.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_next[i]     = filt_reg[i];
      filt_cnt_next[i] = '0;
      if (sync_out[i] != filt_reg[i]) begin
        if (filt_cnt_reg[i] == FW'(FILT_LEN - 1)) begin
          filt_next[i] = sync_out[i];
        end else begin
          filt_cnt_next[i] = filt_cnt_reg[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_reg <= 2'b11;
      for (int i = 0; i < 2; i++) filt_cnt_reg[i] <= '0;
    end else begin
      filt_reg <= filt_next;
      for (int i = 0; i < 2; i++) filt_cnt_reg[i] <= filt_cnt_next[i];
    end
  end

  // Events use the filter's incoming value so the FSM reacts on the same edge.
  assign scl_prev  = filt_reg[0];
  assign scl_cur   = filt_next[0];
  assign sda_prev  = filt_reg[1];
  assign sda_cur   = filt_next[1];
  assign start_det = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_det  = scl_prev & scl_cur & ~sda_prev & sda_cur;

  always_comb begin
    owner_cand = OWNER_NONE;
    for (int i = N_CTRL - 1; i >= 0; i--) begin
      if (ctrl_en[i] & ~ctrl_sda_t[i] & ~ctrl_sda_o[i]) owner_cand = OW'(i);
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    start_cnt_next = start_cnt_reg;
    stuck_cnt_next = stuck_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_BUSY: begin
        if (start_det) begin
          state_next     = ST_BUSY;
          owner_next     = owner_cand;
          start_cnt_next = start_cnt_reg + 16'd1;
        end else if (stop_det && (state_reg == ST_BUSY)) begin
          state_next = ST_IDLE;
          owner_next = OWNER_NONE;
        end
        if (!scl_cur) begin
          if (stuck_cnt_reg != STUCK_MAX) stuck_cnt_next = stuck_cnt_reg + 1'b1;
          if (stuck_cnt_reg >= STUCK_MAX - 1'b1) begin
            state_next = ST_STUCK;
            owner_next = OWNER_NONE;
          end
        end else begin
          stuck_cnt_next = '0;
        end
      end
      ST_STUCK: begin
        stuck_cnt_next = '0;
        if (scl_cur && sda_cur) state_next = ST_IDLE;
      end
      default: begin
        state_next     = ST_IDLE;
        owner_next     = OWNER_NONE;
        stuck_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      owner_reg     <= OWNER_NONE;
      start_cnt_reg <= '0;
      stuck_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      start_cnt_reg <= start_cnt_next;
      stuck_cnt_reg <= stuck_cnt_next;
    end
  end

  assign bus_busy  = (state_reg == ST_BUSY);
  assign bus_stuck = (state_reg == ST_STUCK);
  assign bus_owner = owner_reg;
  assign start_cnt = start_cnt_reg;

endmodule
